// File: rtl/tribus_frame_rx.sv
// tribus_frame_rx: serial frame receiver for a shared single-wire tristate bus.
//   Frame format: start(0), DATA_W data bits LSB first, even parity, stop(1).
//   Received words (with parity/framing flags) are queued in a 2-entry FIFO.
// Ports:
//   CLK    in   clock, rising edge
//   RSTN   in   asynchronous active-low reset
//   BUS    in   tristate bus wire (0/1/Z)
//   DOUT   out  head-of-FIFO data word
//   DPERR  out  head word parity error (qualified by DVALID)
//   DFERR  out  head word framing error (qualified by DVALID)
//   DVALID out  FIFO non-empty
//   DREADY in   consumer accepts head word when DVALID & DREADY
//   OVF    out  1-cycle pulse: frame completed while FIFO full, word dropped
//   BUSY   out  receiver FSM not idle
module tribus_frame_rx #(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              BUS,
  output logic [DATA_W-1:0] DOUT,
  output logic              DPERR,
  output logic              DFERR,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              OVF,
  output logic              BUSY
);
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int EW = DATA_W + 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  state_t            state_q, state_d;
  logic              keep_q, keep_d, s1_q, s2_q, prev_q;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              perr_q, perr_d;
  logic              last, push, pop, full, wr;
  logic [EW-1:0]     mem_q [2];
  logic [EW-1:0]     mem_d [2];
  logic              wp_q, wp_d, rp_q, rp_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  // Bus keeper: follow a driven level, hold the last one while the bus floats.
  assign keep_d = (BUS === 1'b0 || BUS === 1'b1) ? BUS : keep_q;
  assign last   = cyc_q == CW'(BIT_CYC - 1);
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + 1'b1;
    idx_d   = idx_q;
    data_d  = data_q;
    perr_d  = perr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        cyc_d = '0;
        if (prev_q && !s2_q) state_d = START;
      end
      START: if (cyc_q == CW'(BIT_CYC / 2 - 1)) begin
        state_d = s2_q ? IDLE : DATA;
        cyc_d   = '0;
        idx_d   = '0;
      end
      DATA: if (last) begin
        data_d = DATA_W'({s2_q, data_q} >> 1);
        cyc_d  = '0;
        idx_d  = idx_q + 1'b1;
        if (idx_q == IW'(DATA_W - 1)) state_d = PAR;
      end
      PAR: if (last) begin
        perr_d  = (^data_q) ^ s2_q;
        cyc_d   = '0;
        state_d = STOP;
      end
      STOP: if (last) begin
        push    = 1'b1;
        cyc_d   = '0;
        state_d = s2_q ? IDLE : BRK;
      end
      default: begin
        cyc_d = '0;
        if (s2_q) state_d = IDLE;
      end
    endcase
  end
  // A full FIFO still accepts a push when its head is popped in the same cycle.
  always_comb begin
    pop   = (cnt_q != 2'd0) && DREADY;
    full  = cnt_q == 2'd2;
    wr    = push && (!full || pop);
    ovf_d = push && full && !pop;
    mem_d = mem_q;
    if (wr) mem_d[wp_q] = {data_q, perr_q, ~s2_q};
    wp_d  = wp_q ^ wr;
    rp_d  = rp_q ^ pop;
    cnt_d = cnt_q + {1'b0, wr} - {1'b0, pop};
  end
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      keep_q  <= 1'b1;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      cyc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      mem_q   <= '{default: '0};
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      keep_q  <= keep_d;
      s1_q    <= keep_d;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  assign DVALID                = cnt_q != 2'd0;
  assign {DOUT, DPERR, DFERR}  = DVALID ? mem_q[rp_q] : '0;
  assign OVF                   = ovf_q;
  assign BUSY                  = state_q != IDLE;
endmodule
